// File: rtl/mul_hilo_pkg.sv
// Shared definitions for the HI/LO multiply scheduler.
//   state_t      : controller states (IDLE, LAUNCH, RUN, DRAIN)
//   HILO_SEL_*   : encoding of mf_sel for the MFHI/MFLO/MTHI/MTLO selector
package mul_hilo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam logic HILO_SEL_LO = 1'b0;
    localparam logic HILO_SEL_HI = 1'b1;

endpackage

// File: rtl/mul_hilo_sched_arb.sv
// mul_req_arb: two-way fixed-priority grant between the issue pipes.
// Pipe 0 is older in program order and always wins; pipe 1 is only
// granted when pipe 0 is not requesting.
// Ports:
//   en         : controller can accept a new operation this cycle
//   req0_valid : pipe 0 request (blocks pipe 1)
//   flush      : pipeline flush, suppresses any grant
//   mt_valid   : MTHI/MTLO takes the HI/LO port this cycle
//   gnt0/gnt1  : ready to pipe 0 / pipe 1
module mul_req_arb (
    input  logic en,
    input  logic req0_valid,
    input  logic flush,
    input  logic mt_valid,
    output logic gnt0,
    output logic gnt1
);

    logic open;

    assign open = en && !flush && !mt_valid;
    assign gnt0 = open;
    assign gnt1 = open && !req0_valid;

endmodule

// File: rtl/mul_hilo_sched.sv
// mul_hilo_sched: shares one iterative multiplier between two issue pipes,
// sequences each multiply, owns the architectural HI/LO registers and
// interlocks MFHI/MFLO/MTHI/MTLO against in-flight multiplies.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   req{0,1}_valid/_signed/_a/_b: multiply requests (pipe 0 older)
//   req{0,1}_ready              : grant, handshake on valid && ready
//   flush                       : discard the in-flight result
//   mf_valid, mf_sel, mf_data   : HI/LO read (mf_data combinational)
//   mt_valid, mt_data           : HI/LO write, selected by mf_sel
//   hilo_stall                  : stall for the mf/mt issuer
//   done                        : one-cycle pulse when a multiply writes HI/LO
//   mul_start/_signed/_a/_b     : multiplier command
//   mul_busy, mul_s             : multiplier status and product
// Optional build macro MUL_HILO_PERF_EN adds saturating counters
//   perf_ops (completed multiplies) and perf_stall (hilo_stall cycles).
module mul_hilo_sched
    import mul_hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic               req0_signed,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    output logic               req0_ready,
    input  logic               req1_valid,
    input  logic               req1_signed,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               req1_ready,
    input  logic               flush,
    input  logic               mf_valid,
    input  logic               mf_sel,
    output logic [WIDTH-1:0]   mf_data,
    input  logic               mt_valid,
    input  logic [WIDTH-1:0]   mt_data,
    output logic               hilo_stall,
    output logic               done,
    output logic               mul_start,
    output logic               mul_signed,
    output logic [WIDTH-1:0]   mul_a,
    output logic [WIDTH-1:0]   mul_b,
    input  logic               mul_busy,
    input  logic [2*WIDTH-1:0] mul_s
`ifdef MUL_HILO_PERF_EN
    ,
    output logic [31:0]        perf_ops,
    output logic [31:0]        perf_stall
`endif
);

    state_t           state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             arb_en;
    logic             hs0;
    logic             hs1;

    // Grants are only offered in IDLE, never while reset is asserted, and
    // not in the cycle that carries the done pulse (one-bubble turnaround).
    assign arb_en = rst_n && (state == ST_IDLE) && !done;

    mul_req_arb u_arb (
        .en         (arb_en),
        .req0_valid (req0_valid),
        .flush      (flush),
        .mt_valid   (mt_valid),
        .gnt0       (req0_ready),
        .gnt1       (req1_ready)
    );

    assign hs0 = req0_valid && req0_ready;
    assign hs1 = req1_valid && req1_ready;

    assign mf_data    = (mf_sel == HILO_SEL_HI) ? hi : lo;
    assign hilo_stall = (mf_valid || mt_valid) && (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hi         <= '0;
            lo         <= '0;
            mul_start  <= 1'b0;
            mul_signed <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // MT owns HI/LO this cycle; the arbiter already withheld
                    // both grants. A flush leaves HI/LO untouched.
                    if (mt_valid) begin
                        if (!flush) begin
                            if (mf_sel == HILO_SEL_HI) hi <= mt_data;
                            else                       lo <= mt_data;
                        end
                    end else if (hs0) begin
                        mul_a      <= req0_a;
                        mul_b      <= req0_b;
                        mul_signed <= req0_signed;
                        mul_start  <= 1'b1;
                        state      <= ST_LAUNCH;
                    end else if (hs1) begin
                        mul_a      <= req1_a;
                        mul_b      <= req1_b;
                        mul_signed <= req1_signed;
                        mul_start  <= 1'b1;
                        state      <= ST_LAUNCH;
                    end
                end
                // mul_busy is not yet meaningful while start is being presented.
                ST_LAUNCH: begin
                    mul_start <= 1'b0;
                    state     <= flush ? ST_DRAIN : ST_RUN;
                end
                ST_RUN: begin
                    if (!mul_busy) begin
                        // A flush coinciding with completion discards the product.
                        if (!flush) begin
                            hi   <= mul_s[2*WIDTH-1:WIDTH];
                            lo   <= mul_s[WIDTH-1:0];
                            done <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end else if (flush) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!mul_busy) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef MUL_HILO_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (done && (perf_ops != '1))         perf_ops   <= perf_ops + 32'd1;
            if (hilo_stall && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
